// File: rtl/cipher_word_packer_if.sv
// Bus between the ciphertext word packer and its environment: UART byte side,
// the exponentiation-core word handshake, status flags and FSM state for debug.
interface cipher_word_packer_if;
  logic        start;
  logic [31:0] n_key;
  logic        rx_done_tick;
  logic [7:0]  rx_data;
  logic        fme_ready;
  logic        word_valid;
  logic [31:0] word_out;
  logic        last_word_tick;
  logic        busy;
  logic        range_err;
  logic        overrun_err;
  logic [1:0]  state_dbg;

  // Handshake: a word moves in any cycle with word_valid && fme_ready;
  // word_out holds steady while word_valid is high and not yet taken.
  modport master (
    input  start, n_key, rx_done_tick, rx_data, fme_ready,
    output word_valid, word_out, last_word_tick, busy, range_err, overrun_err,
           state_dbg
  );

  modport slave (
    output start, n_key, rx_done_tick, rx_data, fme_ready,
    input  word_valid, word_out, last_word_tick, busy, range_err, overrun_err,
           state_dbg
  );
endinterface

// File: rtl/cipher_word_packer.sv
// Parses a 16-bit little-endian word-count header from received bytes and packs
// the payload into 32-bit little-endian words for the exponentiation core.
module cipher_word_packer (
  input  logic                  clk,
  input  logic                  rst,
  cipher_word_packer_if.master  bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] n_key_buf;
  logic [15:0] n_words;
  logic [15:0] words_done;
  logic [15:0] words_xfer;
  logic        hdr_idx;
  logic [1:0]  byte_idx;
  logic [23:0] asm_reg;
  logic [31:0] hold_reg;
  logic        hold_valid;
  logic        range_flag;
  logic        overrun_flag;

  logic        xfer;
  logic        hold_free;
  logic [31:0] new_word;
  logic [15:0] done_next;

  assign xfer      = hold_valid & bus.fme_ready;
  // The hold register can accept a new word if it is empty or emptying now.
  assign hold_free = ~hold_valid | xfer;
  assign new_word  = {bus.rx_data, asm_reg};
  assign done_next = words_done + 16'd1;

  assign bus.word_valid     = hold_valid;
  assign bus.word_out       = hold_reg;
  assign bus.busy           = (state != IDLE);
  assign bus.last_word_tick = xfer && (words_xfer == (n_words - 16'd1));
  assign bus.range_err      = range_flag;
  assign bus.overrun_err    = overrun_flag;
  assign bus.state_dbg      = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      n_key_buf    <= '0;
      n_words      <= '0;
      words_done   <= '0;
      words_xfer   <= '0;
      hdr_idx      <= 1'b0;
      byte_idx     <= '0;
      asm_reg      <= '0;
      hold_reg     <= '0;
      hold_valid   <= 1'b0;
      range_flag   <= 1'b0;
      overrun_flag <= 1'b0;
    end else begin
      if (xfer) begin
        hold_valid <= 1'b0;
        words_xfer <= words_xfer + 16'd1;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            n_key_buf    <= bus.n_key;
            range_flag   <= 1'b0;
            overrun_flag <= 1'b0;
            n_words      <= '0;
            words_done   <= '0;
            words_xfer   <= '0;
            hdr_idx      <= 1'b0;
            byte_idx     <= '0;
            asm_reg      <= '0;
            state        <= HEADER;
          end
        end

        HEADER: begin
          if (bus.rx_done_tick) begin
            if (!hdr_idx) begin
              n_words[7:0] <= bus.rx_data;
              hdr_idx      <= 1'b1;
            end else begin
              n_words[15:8] <= bus.rx_data;
              hdr_idx       <= 1'b0;
              state <= ({bus.rx_data, n_words[7:0]} == 16'd0) ? IDLE : PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (bus.rx_done_tick) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_reg[7:0]   <= bus.rx_data;
              2'd1: asm_reg[15:8]  <= bus.rx_data;
              2'd2: asm_reg[23:16] <= bus.rx_data;
              default: begin
                if (hold_free) begin
                  hold_reg   <= new_word;
                  hold_valid <= 1'b1;
                  if (new_word >= n_key_buf) range_flag <= 1'b1;
                end else begin
                  overrun_flag <= 1'b1;
                end
                // Dropped words still count toward the stream length.
                words_done <= done_next;
                if (done_next == n_words) state <= DRAIN;
              end
            endcase
          end
        end

        DRAIN: begin
          if (hold_free) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cipher_word_packer.sv
// Directed bench for cipher_word_packer with a word scoreboard checked at
// every handshake transfer.
module tb_cipher_word_packer;
  logic clk;
  logic rst;

  cipher_word_packer_if bus ();

  cipher_word_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  // bit 32 = expected last_word_tick, bits 31:0 = expected word
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks; each starts and ends 1 ns after a rising edge
  task automatic tick_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_done_tick = 1'b1;
    bus.rx_data      = b;
    tick_cycle();
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_header(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic do_start(input logic [31:0] key);
    bus.start = 1'b1;
    bus.n_key = key;
    tick_cycle();
    bus.start = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] w, input logic t);
    exp_q.push_back({t, w});
  endtask

  // scoreboard: compare at every transfer, tick must be low otherwise
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.word_valid && bus.fme_ready) begin
        logic [32:0] e;
        if (exp_q.size() == 0) begin
          check("unexpected_word", bus.word_out, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          check("word_out", bus.word_out, e[31:0]);
          check("last_tick_on_xfer", {31'd0, bus.last_word_tick}, {31'd0, e[32]});
        end
      end else begin
        check("tick_idle", {31'd0, bus.last_word_tick}, 32'd0);
      end
    end
  end

  logic [31:0] w1, w2, w3, wa, wb;

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.n_key        = '0;
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = '0;
    bus.fme_ready    = 1'b0;
    repeat (3) tick_cycle();
    check("rst_word_valid", {31'd0, bus.word_valid}, 32'd0);
    check("rst_word_out", bus.word_out, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_range", {31'd0, bus.range_err}, 32'd0);
    check("rst_overrun", {31'd0, bus.overrun_err}, 32'd0);
    check("rst_tick", {31'd0, bus.last_word_tick}, 32'd0);
    rst = 1'b0;
    tick_cycle();

    // basic stream
    bus.fme_ready = 1'b1;
    push_exp(32'h0000_2211, 1'b0);
    push_exp(32'h0000_4433, 1'b1);
    do_start(32'h0000_C2B5);
    check("basic_busy", {31'd0, bus.busy}, 32'd1);
    send_header(16'd2);
    send_word(32'h0000_2211);
    check("basic_latency", {31'd0, bus.word_valid}, 32'd1);
    send_word(32'h0000_4433);
    check("basic_last_valid", {31'd0, bus.word_valid}, 32'd1);
    check("basic_drain_busy", {31'd0, bus.busy}, 32'd1);
    tick_cycle();
    check("basic_busy_low", {31'd0, bus.busy}, 32'd0);
    check("basic_valid_low", {31'd0, bus.word_valid}, 32'd0);
    check("basic_range", {31'd0, bus.range_err}, 32'd0);
    check("basic_overrun", {31'd0, bus.overrun_err}, 32'd0);
    check("basic_q_empty", exp_q.size(), 32'd0);

    // bytes while idle
    send_word(32'hDEAD_BEEF);
    check("idle_valid", {31'd0, bus.word_valid}, 32'd0);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    // range error
    push_exp(32'h0000_0100, 1'b1);
    do_start(32'h0000_0100);
    send_header(16'd1);
    send_word(32'h0000_0100);
    check("range_set", {31'd0, bus.range_err}, 32'd1);
    tick_cycle();
    check("range_busy_low", {31'd0, bus.busy}, 32'd0);
    repeat (3) tick_cycle();
    check("range_sticky", {31'd0, bus.range_err}, 32'd1);

    // backpressure with overrun of the final word
    w1 = 32'h0403_0201;
    w2 = {8'($urandom_range(0, 254)), 24'($urandom_range(0, 24'hFF_FFFF))};
    w3 = {8'($urandom_range(0, 254)), 24'($urandom_range(0, 24'hFF_FFFF))};
    push_exp(w1, 1'b0);
    do_start(32'hFFFF_FFFF);
    check("start_clears_range", {31'd0, bus.range_err}, 32'd0);
    send_header(16'd3);
    send_word(w1);
    tick_cycle();
    bus.fme_ready = 1'b0;
    send_word(w2);
    check("bp_w2_valid", {31'd0, bus.word_valid}, 32'd1);
    check("bp_no_overrun_yet", {31'd0, bus.overrun_err}, 32'd0);
    send_word(w3);
    check("bp_overrun", {31'd0, bus.overrun_err}, 32'd1);
    check("bp_hold_kept", bus.word_out, w2);
    repeat (10) tick_cycle();
    check("bp_drain_busy", {31'd0, bus.busy}, 32'd1);
    check("bp_hold_stable", bus.word_out, w2);
    push_exp(w2, 1'b0);
    bus.fme_ready = 1'b1;
    tick_cycle();
    check("bp_busy_low", {31'd0, bus.busy}, 32'd0);
    check("bp_valid_low", {31'd0, bus.word_valid}, 32'd0);
    check("bp_overrun_sticky", {31'd0, bus.overrun_err}, 32'd1);
    check("bp_q_empty", exp_q.size(), 32'd0);

    // simultaneous load and transfer, with a start pulse mid-payload
    wa = 32'h0BAD_F00D;
    wb = {8'($urandom_range(0, 254)), 24'($urandom_range(0, 24'hFF_FFFF))};
    bus.fme_ready = 1'b0;
    push_exp(wa, 1'b0);
    push_exp(wb, 1'b1);
    do_start(32'hFFFF_FFFF);
    check("start_clears_overrun", {31'd0, bus.overrun_err}, 32'd0);
    send_header(16'd2);
    send_byte(wa[7:0]);
    send_byte(wa[15:8]);
    bus.start = 1'b1;
    bus.n_key = 32'd0;
    tick_cycle();
    bus.start = 1'b0;
    send_byte(wa[23:16]);
    send_byte(wa[31:24]);
    check("sim_wa_held", bus.word_out, wa);
    send_byte(wb[7:0]);
    send_byte(wb[15:8]);
    send_byte(wb[23:16]);
    bus.fme_ready = 1'b1;
    send_byte(wb[31:24]);
    check("sim_wb_valid", {31'd0, bus.word_valid}, 32'd1);
    check("sim_wb_word", bus.word_out, wb);
    check("sim_no_overrun", {31'd0, bus.overrun_err}, 32'd0);
    tick_cycle();
    check("sim_busy_low", {31'd0, bus.busy}, 32'd0);
    check("sim_start_ignored", {31'd0, bus.range_err}, 32'd0);

    // reset mid-stream, then a fresh stream
    do_start(32'hFFFF_FFFF);
    send_header(16'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    tick_cycle();
    rst = 1'b0;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_valid", {31'd0, bus.word_valid}, 32'd0);
    push_exp(32'hDDCC_BBAA, 1'b1);
    do_start(32'hFFFF_FFFF);
    send_header(16'd1);
    send_word(32'hDDCC_BBAA);
    tick_cycle();
    check("fresh_busy_low", {31'd0, bus.busy}, 32'd0);

    // zero-length stream
    do_start(32'h0000_1234);
    send_byte(8'h00);
    check("zero_busy_mid", {31'd0, bus.busy}, 32'd1);
    send_byte(8'h00);
    check("zero_busy_low", {31'd0, bus.busy}, 32'd0);
    check("zero_valid", {31'd0, bus.word_valid}, 32'd0);
    repeat (4) tick_cycle();
    check("final_q_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
